// File: rtl/scoreboard_register_file_if.sv
// ============================================================================
// Module   : scoreboard_register_file_if
// Brief    : Read, reserve and writeback bundle for the scoreboard register file
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scoreboard_register_file_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 2
);
    localparam int c_NUM_REGS = 2**ADDR_W;

    logic [ADDR_W-1:0]     rd_addr1;
    logic [ADDR_W-1:0]     rd_addr2;
    logic [WORD_SIZE-1:0]  rd_data1;
    logic [WORD_SIZE-1:0]  rd_data2;
    logic                  rd_busy1;
    logic                  rd_busy2;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_addr;
    logic                  rsv_full;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic [c_NUM_REGS-1:0] pending;
    logic                  err;

    modport master (
        output rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_full, pending, err
    );

    modport slave (
        input  rd_addr1, rd_addr2, rsv_en, rsv_addr, wr_en, wr_addr, wr_data,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_full, pending, err
    );
endinterface

`default_nettype wire

// File: rtl/scoreboard_register_file.sv
// ============================================================================
// Module   : scoreboard_register_file
// Brief    : Bypassed 2R/1W register file with per-register outstanding-write counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard_register_file #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 2,
    parameter int CNT_W     = 2
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    scoreboard_register_file_if.slave bus
);
    localparam int               c_NUM_REGS = 2**ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WORD_SIZE-1:0]  r_data    [c_NUM_REGS];
    logic [CNT_W-1:0]      r_cnt     [c_NUM_REGS];
    logic [CNT_W-1:0]      w_cnt_nxt [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] w_rsv_hit;
    logic [c_NUM_REGS-1:0] w_wb_hit;
    logic                  r_err;
    logic                  w_err_set;

    logic                  w_wr_hit1;
    logic                  w_wr_hit2;
    logic [CNT_W-1:0]      w_cnt1;
    logic [CNT_W-1:0]      w_cnt2;

    // Bypass is gated by reset so reads return zero while reset is held.
    assign w_wr_hit1 = reset_n && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    assign w_wr_hit2 = reset_n && bus.wr_en && (bus.wr_addr == bus.rd_addr2);
    assign w_cnt1    = r_cnt[bus.rd_addr1];
    assign w_cnt2    = r_cnt[bus.rd_addr2];

    assign bus.rd_data1 = w_wr_hit1 ? bus.wr_data : r_data[bus.rd_addr1];
    assign bus.rd_data2 = w_wr_hit2 ? bus.wr_data : r_data[bus.rd_addr2];

    // A retiring writeback hides its own outstanding count; a new reservation
    // only becomes visible after the edge.
    assign bus.rd_busy1 = (w_cnt1 > c_CNT_ONE) || ((w_cnt1 == c_CNT_ONE) && !w_wr_hit1);
    assign bus.rd_busy2 = (w_cnt2 > c_CNT_ONE) || ((w_cnt2 == c_CNT_ONE) && !w_wr_hit2);

    assign bus.rsv_full = bus.rsv_en && (r_cnt[bus.rsv_addr] == c_CNT_MAX)
                          && !(bus.wr_en && (bus.wr_addr == bus.rsv_addr));

    assign bus.err = r_err;

    generate
        for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_entry
            assign w_rsv_hit[gi]   = bus.rsv_en && (bus.rsv_addr == ADDR_W'(gi));
            assign w_wb_hit[gi]    = bus.wr_en  && (bus.wr_addr  == ADDR_W'(gi));
            assign bus.pending[gi] = |r_cnt[gi];
        end
    endgenerate

    always_comb begin
        w_err_set = 1'b0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_rsv_hit[i] && !w_wb_hit[i]) begin
                if (r_cnt[i] == c_CNT_MAX) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + c_CNT_ONE;
                end
            end else if (w_wb_hit[i] && !w_rsv_hit[i]) begin
                if (r_cnt[i] == '0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_data[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_err <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                r_data[bus.wr_addr] <= bus.wr_data;
            end
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_scoreboard_register_file.sv
// ============================================================================
// Module   : tb_scoreboard_register_file
// Brief    : Directed and randomized checks of scoreboard_register_file against a queue-free reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scoreboard_register_file;
    localparam int WORD_SIZE = 16;
    localparam int ADDR_W    = 2;
    localparam int CNT_W     = 2;
    localparam int NREG      = 4;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    scoreboard_register_file_if #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) bus ();

    scoreboard_register_file #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int mdata [NREG];
    int mcnt  [NREG];
    bit merr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mdata[i] = 0;
            mcnt[i]  = 0;
        end
        merr = 1'b0;
    endtask

    // Expected outputs for the inputs currently on the bus.
    task automatic check_all();
        int  a1, a2, exp_d1, exp_d2, outstanding;
        bit  w1, w2;
        logic [NREG-1:0] exp_p;
        a1 = int'(bus.rd_addr1);
        a2 = int'(bus.rd_addr2);
        w1 = reset_n && bus.wr_en && (int'(bus.wr_addr) == a1);
        w2 = reset_n && bus.wr_en && (int'(bus.wr_addr) == a2);
        exp_d1 = w1 ? int'(bus.wr_data) : mdata[a1];
        exp_d2 = w2 ? int'(bus.wr_data) : mdata[a2];
        check("rd_data1", 32'(bus.rd_data1), 32'(exp_d1));
        check("rd_data2", 32'(bus.rd_data2), 32'(exp_d2));
        outstanding = mcnt[a1] - (w1 ? 1 : 0);
        check("rd_busy1", 32'(bus.rd_busy1), 32'(outstanding > 0));
        outstanding = mcnt[a2] - (w2 ? 1 : 0);
        check("rd_busy2", 32'(bus.rd_busy2), 32'(outstanding > 0));
        check("rsv_full", 32'(bus.rsv_full),
              32'(bus.rsv_en && mcnt[int'(bus.rsv_addr)] == CMAX &&
                  !(bus.wr_en && bus.wr_addr == bus.rsv_addr)));
        for (int i = 0; i < NREG; i++) exp_p[i] = (mcnt[i] != 0);
        check("pending", 32'(bus.pending), 32'(exp_p));
        check("err", 32'(bus.err), 32'(merr));
    endtask

    task automatic drive(input bit re, input int ra, input bit we, input int wa,
                         input int wd, input int a1, input int a2);
        bus.rsv_en   = re;
        bus.rsv_addr = ra[ADDR_W-1:0];
        bus.wr_en    = we;
        bus.wr_addr  = wa[ADDR_W-1:0];
        bus.wr_data  = wd[WORD_SIZE-1:0];
        bus.rd_addr1 = a1[ADDR_W-1:0];
        bus.rd_addr2 = a2[ADDR_W-1:0];
        #4;
        check_all();
    endtask

    // Advance one edge; the counter moves by (+1 reserve, -1 writeback) and
    // any result outside [0, CMAX] is refused and flagged.
    task automatic step();
        int n;
        @(posedge clk);
        for (int i = 0; i < NREG; i++) begin
            n = mcnt[i] + ((bus.rsv_en && int'(bus.rsv_addr) == i) ? 1 : 0)
                        - ((bus.wr_en  && int'(bus.wr_addr)  == i) ? 1 : 0);
            if (n < 0 || n > CMAX) merr = 1'b1;
            else                   mcnt[i] = n;
        end
        if (bus.wr_en) mdata[int'(bus.wr_addr)] = int'(bus.wr_data);
        #1;
    endtask

    task automatic idle(input int a1, input int a2);
        drive(1'b0, 0, 1'b0, 0, 0, a1, a2);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Write with same-cycle bypass, then from storage.
        drive(1'b0, 0, 1'b1, 2, 'h1234, 2, 0);
        check("bypass_1234", 32'(bus.rd_data1), 32'h1234);
        step();
        idle(2, 1);
        check("stored_1234", 32'(bus.rd_data1), 32'h1234);
        check("other_zero", 32'(bus.rd_data2), 32'h0);
        step();

        // Reserve r1, busy next cycle, writeback drops busy.
        drive(1'b1, 1, 1'b0, 0, 0, 1, 1);
        check("busy_same_cycle", 32'(bus.rd_busy1), 32'h0);
        step();
        idle(1, 0);
        check("busy_r1", 32'(bus.rd_busy1), 32'h1);
        check("pending_r1", 32'(bus.pending), 32'h2);
        step();
        drive(1'b0, 0, 1'b1, 1, 'hBEEF, 1, 1);
        check("busy_drop", 32'(bus.rd_busy1), 32'h0);
        check("wb_beef", 32'(bus.rd_data1), 32'hBEEF);
        step();
        idle(1, 0);
        check("pending_clear", 32'(bus.pending), 32'h0);
        step();

        // Saturate r3.
        repeat (3) begin
            drive(1'b1, 3, 1'b0, 0, 0, 3, 0);
            step();
        end
        drive(1'b1, 3, 1'b0, 0, 0, 3, 0);
        check("rsv_full_r3", 32'(bus.rsv_full), 32'h1);
        step();
        idle(3, 0);
        check("err_overflow", 32'(bus.err), 32'h1);
        check("pending_r3", 32'(bus.pending), 32'h8);
        step();
        repeat (3) begin
            drive(1'b0, 0, 1'b1, 3, $urandom, 3, 0);
            step();
        end
        idle(3, 0);
        check("r3_drained", 32'(bus.pending), 32'h0);
        step();

        // Simultaneous reserve/writeback on r0.
        pulse_reset();
        drive(1'b1, 0, 1'b0, 0, 0, 0, 0);
        step();
        drive(1'b1, 0, 1'b1, 0, 'h55, 0, 0);
        step();
        idle(0, 0);
        check("sim_cnt1", 32'(bus.pending), 32'h1);
        check("sim_err0", 32'(bus.err), 32'h0);
        step();
        drive(1'b0, 0, 1'b1, 0, 'h56, 0, 0);
        step();
        drive(1'b1, 0, 1'b1, 0, 'h66, 0, 0);
        step();
        idle(0, 0);
        check("sim_cnt0", 32'(bus.pending), 32'h0);
        check("sim_no_underflow", 32'(bus.err), 32'h0);
        step();

        // Underflow on r2, error stays sticky.
        drive(1'b0, 0, 1'b1, 2, 'hA5A5, 2, 0);
        step();
        idle(2, 0);
        check("uf_data", 32'(bus.rd_data1), 32'hA5A5);
        check("uf_err", 32'(bus.err), 32'h1);
        step();
        drive(1'b1, 1, 1'b0, 0, 0, 1, 2);
        step();
        drive(1'b0, 0, 1'b1, 1, 'h0101, 1, 2);
        step();
        idle(1, 2);
        check("err_sticky", 32'(bus.err), 32'h1);
        step();

        // Asynchronous reset mid-cycle with r1 pending holding 0x00FF.
        drive(1'b0, 0, 1'b1, 1, 'h00FF, 1, 0);
        step();
        drive(1'b1, 1, 1'b0, 0, 0, 1, 0);
        step();
        idle(1, 0);
        check("pre_rst_pend", 32'(bus.pending), 32'h2);
        check("pre_rst_data", 32'(bus.rd_data1), 32'h00FF);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_pend", 32'(bus.pending), 32'h0);
        check("async_data", 32'(bus.rd_data1), 32'h0);
        check("async_err", 32'(bus.err), 32'h0);
        check("async_busy", 32'(bus.rd_busy1), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic, with an occasional reset to clear err.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 2) != 0, int'($urandom_range(0, NREG-1)),
                      $urandom_range(0, 2) != 0, int'($urandom_range(0, NREG-1)),
                      int'($urandom_range(0, 16'hFFFF)),
                      int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)));
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised general-purpose register file for the pipelined CPU: two combinational read ports, one write port and same-cycle write-to-read bypass. Each register carries an outstanding-write counter that the issue stage reserves and writeback releases. The block reports per-operand busy flags that the hazard unit uses to stall. It replaces the fixed four-entry, unbypassed register file in the datapath.

## Interface
Parameters:
- WORD_SIZE, 16, data width of each register
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W
- CNT_W, 2, width of each outstanding-write counter; maximum count 2**CNT_W-1

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr1, rd_addr2  in  ADDR_W  read port addresses
- rd_data1, rd_data2  out  WORD_SIZE  read port data, bypassed
- rd_busy1, rd_busy2  out  1  addressed register still has unretired writes
- rsv_en  in  1  issue stage reserves a destination this cycle
- rsv_addr  in  ADDR_W  register being reserved
- rsv_full  out  1  counter at rsv_addr saturated; the reservation is refused
- wr_en  in  1  writeback commits this cycle
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  WORD_SIZE  writeback value
- pending  out  NUM_REGS  bit i = counter i nonzero (registered view)
- err  out  1  sticky protocol-error flag

## Operation
- Storage: NUM_REGS × WORD_SIZE data registers and NUM_REGS × CNT_W counters.
- Read, combinational, per port p:
  - rd_data_p = wr_data if wr_en and wr_addr == rd_addr_p.
  - Otherwise rd_data_p = the stored value.
- Busy, combinational, per port p, with c = counter[rd_addr_p] and w = (wr_en and wr_addr == rd_addr_p):
  - rd_busy_p = (c > 1) or (c == 1 and not w).
  - A same-cycle reservation does not raise busy.
- Write: on the rising edge with wr_en, register[wr_addr] <= wr_data. Writes are unconditional and never depend on the counter.
- Counter update per entry i, at the rising edge:
  - Reserve only (rsv_en, rsv_addr == i, no writeback to i), count < max: +1.
  - Reserve only, count == max: unchanged, and err is set.
  - Writeback only (wr_en, wr_addr == i, no reserve to i), count > 0: −1.
  - Writeback only, count == 0: unchanged, and err is set (underflow).
  - Reserve and writeback to the same i in one cycle: unchanged, even at 0 or at max; no error.
- rsv_full = rsv_en and counter[rsv_addr] == max and not (wr_en and wr_addr == rsv_addr).
- err is sticky and clears only on reset.
- Register 0 is an ordinary register; it is not hardwired to zero.

## Timing
- Reset (reset_n low, asynchronous) sets all data registers, counters and err to 0. Consequently rd_data* = 0, rd_busy* = 0, pending = 0 and rsv_full = 0 while reset is asserted.
  - Deassertion is sampled at the next rising clk edge.
  - A reset mid-operation discards every outstanding reservation.
- Read latency is zero: outputs follow addresses and the write port within the same cycle.
- A write is visible through bypass in its own cycle and from storage in the following cycle.
- A reservation raises the counter at edge N; rd_busy on that address is first high in cycle N+1.
- pending reflects the counters after the edge; it does not include same-cycle bypass.
- wr_en and rsv_en are single-cycle strobes; no handshake or back-pressure beyond rsv_full.

## Test plan
- Reset, then write 0x1234 to r2 → rd_data1 (addr 2) = 0x1234 in the write cycle via bypass, and still 0x1234 the next cycle from storage. Other registers read 0.
- Reserve r1, then in the next cycle read r1 → rd_busy1 = 1 and pending = 4'b0010. Writeback r1 = 0xBEEF → busy drops in the same cycle, data = 0xBEEF, and pending = 0 after the edge.
- Reserve r3 three times (CNT_W = 2) → counter 3. A fourth reserve gives rsv_full = 1, the counter stays 3 and err = 1. Three writebacks then bring the counter to 0.
- Simultaneous rsv_en and wr_en to r0 with counter 1 → counter stays 1 and err stays 0. With counter 0, the counter stays 0 and no underflow is flagged.
- Writeback to r2 with counter 0 → data is written and err = 1, and err stays 1 across later correct traffic.
- Assert reset_n low mid-cycle with r1 pending and data 0x00FF → pending, rd_data and err read 0 immediately, with no clock edge needed.
